// File: rtl/instr_mem_responder_if.sv
// Fetch-read and byte-serial load bus of the instruction memory responder.
// The master drives fetch requests and load bytes; the slave is the responder.
interface instr_mem_responder_if #(
  parameter int MEM_WIDTH = 32,
  parameter int AW        = 8
);
  logic [AW-1:0]        mem_addr;
  logic                 mem_read_en;
  logic [MEM_WIDTH-1:0] mem_read_val;
  logic                 load_start;
  logic [AW-1:0]        load_base;
  logic [7:0]           load_byte;
  logic                 load_valid;
  logic                 load_last;
  logic                 load_ready;
  logic                 load_busy;
  logic                 load_done;
  logic                 load_wrap;

  modport master (
    output mem_addr, mem_read_en, load_start, load_base, load_byte, load_valid, load_last,
    input  mem_read_val, load_ready, load_busy, load_done, load_wrap
  );

  modport slave (
    input  mem_addr, mem_read_en, load_start, load_base, load_byte, load_valid, load_last,
    output mem_read_val, load_ready, load_busy, load_done, load_wrap
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory: fetch read port plus a byte-serial load FSM that packs bytes into words.
// Define INSTR_MEM_READ_REG_EN to register mem_read_val (1-cycle read latency).
module instr_mem_responder #(
  parameter int  MEM_WIDTH = 32,
  parameter int  MEM_SIZE  = 256,
  localparam int AW        = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instr_mem_responder_if.slave  bus
);
  localparam int BYTES = MEM_WIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_SIZE - 1);
  localparam logic [BW-1:0] LAST_IDX  = BW'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_r;
  logic [BW-1:0]        byte_idx_r;
  logic [MEM_WIDTH-1:0] word_buf_r;
  logic [AW-1:0]        wr_addr_r;
  logic                 last_seen_r;
  logic                 load_ready_r;
  logic                 load_busy_r;
  logic                 load_done_r;
  logic                 load_wrap_r;
  logic [MEM_WIDTH-1:0] mem_r [MEM_SIZE];

  logic                 accept_s;
  logic                 addr_ok_s;
  logic                 base_ok_s;
  logic [MEM_WIDTH-1:0] read_s;

  // Byte handshake, address range qualification and the combinational fetch value.
  always_comb begin
    accept_s  = bus.load_valid & load_ready_r;
    addr_ok_s = ({1'b0, bus.mem_addr}  < (AW+1)'(MEM_SIZE));
    base_ok_s = ({1'b0, bus.load_base} < (AW+1)'(MEM_SIZE));
    if (bus.mem_read_en && !load_busy_r && addr_ok_s) begin
      read_s = mem_r[bus.mem_addr];
    end else begin
      read_s = '0;
    end
  end

  // Load FSM; ready/busy/done are registered alongside the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      byte_idx_r   <= '0;
      word_buf_r   <= '0;
      wr_addr_r    <= '0;
      last_seen_r  <= 1'b0;
      load_ready_r <= 1'b0;
      load_busy_r  <= 1'b0;
      load_done_r  <= 1'b0;
      load_wrap_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          load_done_r <= 1'b0;
          if (bus.load_start) begin
            // An out-of-range base would never be writable, so fold it to word 0.
            wr_addr_r    <= base_ok_s ? bus.load_base : '0;
            byte_idx_r   <= '0;
            word_buf_r   <= '0;
            load_wrap_r  <= 1'b0;
            load_ready_r <= 1'b1;
            load_busy_r  <= 1'b1;
            state_r      <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept_s) begin
            word_buf_r[{byte_idx_r, 3'b000} +: 8] <= bus.load_byte;
            if (byte_idx_r == LAST_IDX || bus.load_last) begin
              last_seen_r  <= bus.load_last;
              load_ready_r <= 1'b0;
              state_r      <= WRITE;
            end else begin
              byte_idx_r <= byte_idx_r + BW'(1);
            end
          end
        end
        WRITE: begin
          if (wr_addr_r == LAST_ADDR) begin
            wr_addr_r   <= '0;
            load_wrap_r <= 1'b1;
          end else begin
            wr_addr_r <= wr_addr_r + AW'(1);
          end
          byte_idx_r   <= '0;
          word_buf_r   <= '0;
          load_ready_r <= ~last_seen_r;
          load_done_r  <= last_seen_r;
          state_r      <= last_seen_r ? DONE : COLLECT;
        end
        DONE: begin
          load_done_r <= 1'b0;
          load_busy_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          load_ready_r <= 1'b0;
          load_busy_r  <= 1'b0;
          load_done_r  <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (state_r == WRITE) begin
      mem_r[wr_addr_r] <= word_buf_r;
    end
  end

`ifdef INSTR_MEM_READ_REG_EN
  logic [MEM_WIDTH-1:0] read_r;

  // Registered fetch data; holds while no read is requested.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_r <= '0;
    end else if (bus.mem_read_en) begin
      read_r <= read_s;
    end
  end

  assign bus.mem_read_val = read_r;
`else
  assign bus.mem_read_val = read_s;
`endif

  assign bus.load_ready = load_ready_r;
  assign bus.load_busy  = load_busy_r;
  assign bus.load_done  = load_done_r;
  assign bus.load_wrap  = load_wrap_r;
endmodule
